// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Runs one data-memory transaction per instruction using a
//            req/gnt/rvalid handshake. Builds byte enables and lane-replicated
//            store data, sign/zero-extends load data, and holds the core with
//            a stall request until the access completes.
// Config   : LSU_MISALIGN_CHECK_EN - when defined, misaligned half/word
//            accesses are dropped in IDLE and flagged on lsu_misaligned.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_size,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_stall_req,
  output logic              data_req,
  output logic              data_we,
  output logic [3:0]        data_be,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_gnt,
  input  logic              data_rvalid,
  input  logic [DATA_W-1:0] data_rdata
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic              lsu_misaligned
`endif
);

  // Decoder memory_size codes (bit 2 marks the unsigned load variants)
  localparam logic [2:0] C_SIZE_BYTE   = 3'b000;
  localparam logic [2:0] C_SIZE_HALF   = 3'b001;
  localparam logic [2:0] C_SIZE_WORD   = 3'b010;
  localparam logic [2:0] C_SIZE_U_BYTE = 3'b100;
  localparam logic [2:0] C_SIZE_U_HALF = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              w_is_byte, w_is_half, w_is_word, w_size_ok, w_start;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [7:0]        w_lane_b;
  logic [15:0]       w_lane_h;
  logic [DATA_W-1:0] w_load_ext;
`ifdef LSU_MISALIGN_CHECK_EN
  logic              w_misaligned;
`endif

  // Decode size class, byte enables and replicated store data from the request
  always_comb begin
    w_is_byte = (lsu_size == C_SIZE_BYTE) || (lsu_size == C_SIZE_U_BYTE);
    w_is_half = (lsu_size == C_SIZE_HALF) || (lsu_size == C_SIZE_U_HALF);
    w_is_word = (lsu_size == C_SIZE_WORD);
    w_size_ok = w_is_byte | w_is_half | w_is_word;
    w_be      = 4'b0000;
    w_wdata   = lsu_wdata;
    if (w_is_byte) begin
      w_be    = 4'b0001 << lsu_addr[1:0];
      w_wdata = {4{lsu_wdata[7:0]}};
    end else if (w_is_half) begin
      w_be    = 4'b0011 << {lsu_addr[1], 1'b0};
      w_wdata = {2{lsu_wdata[15:0]}};
    end else if (w_is_word) begin
      w_be    = 4'b1111;
    end
`ifdef LSU_MISALIGN_CHECK_EN
    w_misaligned = (w_is_half & lsu_addr[0]) | (w_is_word & (lsu_addr[1:0] != 2'b00));
    w_start      = lsu_req & w_size_ok & ~w_misaligned;
`else
    w_start      = lsu_req & w_size_ok;
`endif
  end

  // Select and extend the addressed lane of the returned read word
  always_comb begin
    w_lane_b   = data_rdata[8*off_q +: 8];
    w_lane_h   = off_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    w_load_ext = data_rdata;
    case (size_q)
      C_SIZE_BYTE:   w_load_ext = {{24{w_lane_b[7]}}, w_lane_b};
      C_SIZE_U_BYTE: w_load_ext = {24'h0, w_lane_b};
      C_SIZE_HALF:   w_load_ext = {{16{w_lane_h[15]}}, w_lane_h};
      C_SIZE_U_HALF: w_load_ext = {16'h0, w_lane_h};
      default:       w_load_ext = data_rdata;
    endcase
  end

  // Next-state logic for the transaction FSM and its captured request fields
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (w_start) begin
          state_d = REQ;
          we_d    = lsu_we;
          size_d  = lsu_size;
          off_d   = lsu_addr[1:0];
          addr_d  = {lsu_addr[ADDR_W-1:2], 2'b00};
          be_d    = w_be;
          wdata_d = w_wdata;
        end
      end
      REQ: begin
        if (data_gnt) state_d = RESP;
      end
      RESP: begin
        if (data_rvalid) begin
          state_d = IDLE;
          if (!we_q) rdata_d = w_load_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request-field registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'b000;
      off_q   <= 2'b00;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Stall: in IDLE only for an access that will actually start; afterwards
  // until the rvalid cycle, on which the core is released.
  always_comb begin
    if (state_q == IDLE) lsu_stall_req = w_start;
    else                 lsu_stall_req = lsu_req & ~((state_q == RESP) & data_rvalid);
  end

  assign data_req   = (state_q == REQ);
  assign data_we    = we_q;
  assign data_be    = be_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign lsu_rdata  = rdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign lsu_misaligned = (state_q == IDLE) & lsu_req & w_size_ok & w_misaligned;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit with a simple
//            memory responder and a queue of expected load results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam logic [2:0] C_BYTE   = 3'b000;
  localparam logic [2:0] C_HALF   = 3'b001;
  localparam logic [2:0] C_WORD   = 3'b010;
  localparam logic [2:0] C_U_BYTE = 3'b100;
  localparam logic [2:0] C_U_HALF = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        lsu_stall_req;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        lsu_misaligned;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_rdata;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lsu_req       (lsu_req),
    .lsu_we        (lsu_we),
    .lsu_size      (lsu_size),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_rdata     (lsu_rdata),
    .lsu_stall_req (lsu_stall_req),
    .data_req      (data_req),
    .data_we       (data_we),
    .data_be       (data_be),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_gnt      (data_gnt),
    .data_rvalid   (data_rvalid),
    .data_rdata    (data_rdata)
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    .lsu_misaligned(lsu_misaligned)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference extension of a read word for a given size and byte offset
  function automatic logic [31:0] ext_model(input logic [2:0] sz, input logic [1:0] off,
                                            input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (off * 8);
    case (sz)
      C_BYTE:   return {{24{sh[7]}}, sh[7:0]};
      C_U_BYTE: return {24'h0, sh[7:0]};
      C_HALF:   return off[1] ? {{16{rd[31]}}, rd[31:16]} : {{16{rd[15]}}, rd[15:0]};
      C_U_HALF: return off[1] ? {16'h0, rd[31:16]} : {16'h0, rd[15:0]};
      default:  return rd;
    endcase
  endfunction

  // One full transaction with a programmable grant and response delay
  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int gnt_dly, input int rv_dly, input logic stray,
                        input logic [3:0] ebe, input logic [31:0] ewd);
    lsu_req = 1'b1; lsu_we = we; lsu_size = sz; lsu_addr = addr; lsu_wdata = wd;
    data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = 32'h0;
    if (!we) sb.push_back(ext_model(sz, addr[1:0], rd));
    #1;
    check("stall_idle", {31'h0, lsu_stall_req}, 32'd1);
    check("req_idle", {31'h0, data_req}, 32'd0);
    tick();
    for (int k = 0; k <= gnt_dly; k++) begin
      data_gnt    = (k == gnt_dly);
      data_rvalid = stray && (k == 0) && (gnt_dly > 0);
      data_rdata  = 32'h0BAD0BAD;
      #1;
      check("req_held", {31'h0, data_req}, 32'd1);
      check("stall_req", {31'h0, lsu_stall_req}, 32'd1);
      check("addr", data_addr, addr & 32'hFFFF_FFFC);
      check("be", {28'h0, data_be}, {28'h0, ebe});
      check("we", {31'h0, data_we}, {31'h0, we});
      if (we) check("wdata", data_wdata, ewd);
      tick();
    end
    data_gnt = 1'b0;
    for (int k = 0; k <= rv_dly; k++) begin
      data_rvalid = (k == rv_dly);
      data_rdata  = (k == rv_dly) ? rd : 32'h0BAD0BAD;
      #1;
      check("req_resp", {31'h0, data_req}, 32'd0);
      check("stall_resp", {31'h0, lsu_stall_req}, (k == rv_dly) ? 32'd0 : 32'd1);
      tick();
    end
    data_rvalid = 1'b0;
    lsu_req     = 1'b0;
    if (!we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard: observed empty expected entry");
      end else begin
        exp_rdata = sb.pop_front();
      end
    end
    #1;
    check("rdata", lsu_rdata, exp_rdata);
    check("req_done", {31'h0, data_req}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = C_WORD;
    lsu_addr = 32'h0; lsu_wdata = 32'h0;
    data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = 32'h0;
    exp_rdata = 32'h0;
    tick(); tick();
    check("rst_req", {31'h0, data_req}, 32'd0);
    check("rst_we", {31'h0, data_we}, 32'd0);
    check("rst_be", {28'h0, data_be}, 32'd0);
    check("rst_addr", data_addr, 32'd0);
    check("rst_wdata", data_wdata, 32'd0);
    check("rst_rdata", lsu_rdata, 32'd0);
    check("rst_stall", {31'h0, lsu_stall_req}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Word store, immediate grant, response next cycle
    access(1'b1, C_WORD, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 4'hF, 32'hDEADBEEF);
    // Byte store to lane 3
    access(1'b1, C_BYTE, 32'h203, 32'h000000A5, 32'h0, 0, 0, 1'b0, 4'b1000, 32'hA5A5A5A5);
    // Half store to upper half
    access(1'b1, C_HALF, 32'h302, 32'hFFFF1234, 32'h0, 0, 0, 1'b0, 4'b1100, 32'h12341234);
    // Loads with sign and zero extension
    access(1'b0, C_BYTE, 32'h102, 32'h0, 32'h12F45678, 0, 0, 1'b0, 4'b0100, 32'h0);
    access(1'b0, C_U_BYTE, 32'h102, 32'h0, 32'h12F45678, 0, 0, 1'b0, 4'b0100, 32'h0);
    access(1'b0, C_U_HALF, 32'h102, 32'h0, 32'h12F45678, 0, 0, 1'b0, 4'b1100, 32'h0);
    access(1'b0, C_HALF, 32'h100, 32'h0, 32'h00008001, 0, 0, 1'b0, 4'b0011, 32'h0);
    // Delayed grant and response, stray rvalid during REQ
    access(1'b0, C_WORD, 32'h400, 32'h0, 32'hA1B2C3D4, 3, 1, 1'b1, 4'hF, 32'h0);
    // A store does not disturb the last load result
    access(1'b1, C_BYTE, 32'h500, 32'h00000077, 32'h0, 1, 2, 1'b0, 4'b0001, 32'h77777777);

    // Undefined size code: no access, no stall
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'b011; lsu_addr = 32'h600;
    #1;
    check("undef_stall", {31'h0, lsu_stall_req}, 32'd0);
    tick();
    lsu_req = 1'b0;
    #1;
    check("undef_req", {31'h0, data_req}, 32'd0);
    check("undef_rdata", lsu_rdata, exp_rdata);

    // Reset while waiting for the response; late rvalid must be ignored
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = C_WORD; lsu_addr = 32'h700;
    tick();
    data_gnt = 1'b1;
    tick();
    data_gnt = 1'b0;
    rst_n = 1'b0; lsu_req = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_rdata = 32'h0;
    tick();
    data_rvalid = 1'b1; data_rdata = 32'h55555555;
    tick();
    data_rvalid = 1'b0;
    #1;
    check("abort_req", {31'h0, data_req}, 32'd0);
    check("abort_we", {31'h0, data_we}, 32'd0);
    check("abort_be", {28'h0, data_be}, 32'd0);
    check("abort_addr", data_addr, 32'd0);
    check("abort_wdata", data_wdata, 32'd0);
    check("abort_rdata", lsu_rdata, 32'd0);
    check("abort_stall", {31'h0, lsu_stall_req}, 32'd0);
    // FSM back in IDLE: a fresh load runs normally
    access(1'b0, C_U_BYTE, 32'h801, 32'h0, 32'h0000C300, 0, 0, 1'b0, 4'b0010, 32'h0);

    // Misaligned word access
`ifdef LSU_MISALIGN_CHECK_EN
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = C_WORD; lsu_addr = 32'h101;
    #1;
    check("mis_stall", {31'h0, lsu_stall_req}, 32'd0);
    check("mis_flag", {31'h0, lsu_misaligned}, 32'd1);
    tick();
    lsu_req = 1'b0;
    #1;
    check("mis_req", {31'h0, data_req}, 32'd0);
    check("mis_flag_off", {31'h0, lsu_misaligned}, 32'd0);
    check("mis_rdata", lsu_rdata, exp_rdata);
`else
    access(1'b0, C_WORD, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0, 1'b0, 4'hF, 32'h0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
